// File: rtl/web_resource_checker.sv
// Resource gate behind the web-type decoder: validates fluid, energy, tracer
// stock and temperature for each request, fires timed shots and runs reloads.
module web_resource_checker #(
  parameter int unsigned FLUID_MAX     = 15,
  parameter int unsigned TRACER_INIT   = 40,
  parameter int unsigned TEMP_LIMIT    = 12,
  parameter int unsigned COOLDOWN      = 4,
  parameter int unsigned RELOAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic [7:0] choice_i,
  input  logic [7:0] energy_i,
  input  logic [3:0] fluidtemp_i,
  output logic       ready_o,
  output logic       fire_o,
  output logic [7:0] fire_type_o,
  output logic [7:0] energy_draw_o,
  output logic [3:0] fluid_level_o,
  output logic [5:0] tracer_count_o,
  output logic       done_o,
  output logic [2:0] status_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FIRE, S_BURST, S_RESP, S_COOLDOWN, S_RELOAD
  } state_e;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_NO_FLUID  = 3'd1,
    ST_NO_ENERGY = 3'd2,
    ST_NO_TRACER = 3'd3,
    ST_OVERHEAT  = 3'd4,
    ST_BAD       = 3'd5
  } status_e;

  localparam logic [3:0] FLUID_MAX_C   = 4'(FLUID_MAX);
  localparam logic [5:0] TRACER_INIT_C = 6'(TRACER_INIT);
  localparam logic [3:0] TEMP_LIMIT_C  = 4'(TEMP_LIMIT);
  localparam logic [7:0] COOL_LAST     = 8'(COOLDOWN - 1);
  localparam logic [7:0] RELOAD_DONE   = 8'(RELOAD_CYCLES - 2);
  localparam logic [7:0] RELOAD_LAST   = 8'(RELOAD_CYCLES - 1);

  state_e      state_q, state_d;
  status_e     status_q, status_d;
  logic [7:0]  choice_q, choice_d;
  logic        ready_q, ready_d;
  logic        fire_q, fire_d;
  logic [7:0]  fire_type_q, fire_type_d;
  logic [7:0]  energy_draw_q, energy_draw_d;
  logic        done_q, done_d;
  logic [3:0]  fluid_q, fluid_d;
  logic [5:0]  tracer_q, tracer_d;
  logic [1:0]  shot_q, shot_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        resp_cool_q, resp_cool_d;

  // Per-shot cost of the latched choice; non-one-hot patterns cost nothing
  // because they are rejected before any counter is touched.
  logic [3:0]  fluid_cost;
  logic [7:0]  energy_cost;
  logic        tracer_cost;
  logic        is_reload, is_rapid, is_tracer, one_hot;
  status_e     check_status;
  logic [7:0]  burst_need;

  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fluid_cost  = 4'd0;
    energy_cost = 8'd0;
    tracer_cost = 1'b0;
    case (choice_q)
      8'h80: begin fluid_cost = 4'd1; energy_cost = 8'd2;  end
      8'h40: begin fluid_cost = 4'd1; energy_cost = 8'd4;  end
      8'h20: begin fluid_cost = 4'd2; energy_cost = 8'd6;  end
      8'h10: begin fluid_cost = 4'd4; energy_cost = 8'd10; end
      8'h08: begin fluid_cost = 4'd1; energy_cost = 8'd20; end
      8'h04: begin fluid_cost = 4'd1; energy_cost = 8'd2;  end
      8'h02: begin tracer_cost = 1'b1; energy_cost = 8'd3; end
      default: ;
    endcase
  end

  assign one_hot   = (choice_q != 8'd0) && ((choice_q & (choice_q - 8'd1)) == 8'd0);
  assign is_reload = (choice_q == 8'h01);
  assign is_rapid  = (choice_q == 8'h04);
  assign is_tracer = (choice_q == 8'h02);

  // Energy needed before later burst shot k is 2*(k+1); shot_q already equals k.
  assign burst_need = {5'd0, shot_q, 1'b0} + 8'd2;

  always_comb begin
    check_status = ST_OK;
    if (!one_hot)                                      check_status = ST_BAD;
    else if (!is_reload && fluidtemp_i > TEMP_LIMIT_C) check_status = ST_OVERHEAT;
    else if (is_tracer && tracer_q == 6'd0)            check_status = ST_NO_TRACER;
    else if (fluid_q < fluid_cost)                     check_status = ST_NO_FLUID;
    else if (energy_i < energy_cost)                   check_status = ST_NO_ENERGY;
  end

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    choice_d      = choice_q;
    ready_d       = ready_q;
    fire_d        = 1'b0;
    fire_type_d   = fire_type_q;
    energy_draw_d = 8'd0;
    done_d        = 1'b0;
    fluid_d       = fluid_q;
    tracer_d      = tracer_q;
    shot_d        = shot_q;
    cnt_d         = cnt_q;
    resp_cool_d   = resp_cool_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          choice_d = choice_i;
          ready_d  = 1'b0;
          state_d  = S_CHECK;
        end
      end

      S_CHECK: begin
        if (check_status != ST_OK) begin
          done_d      = 1'b1;
          status_d    = check_status;
          resp_cool_d = 1'b0;
          state_d     = S_RESP;
        end else if (is_reload) begin
          cnt_d   = 8'd0;
          state_d = S_RELOAD;
        end else begin
          fire_d        = 1'b1;
          fire_type_d   = choice_q;
          energy_draw_d = energy_cost;
          fluid_d       = fluid_q - fluid_cost;
          tracer_d      = tracer_q - {5'd0, tracer_cost};
          if (is_rapid) begin
            shot_d  = 2'd1;
            state_d = S_BURST;
          end else begin
            done_d   = 1'b1;
            status_d = ST_OK;
            state_d  = S_FIRE;
          end
        end
      end

      S_FIRE: begin
        cnt_d   = 8'd0;
        state_d = S_COOLDOWN;
      end

      // At least one shot has left by now, so every exit goes through cooldown.
      S_BURST: begin
        resp_cool_d = 1'b1;
        state_d     = S_RESP;
        if (shot_q == 2'd3) begin
          done_d   = 1'b1;
          status_d = ST_OK;
        end else if (fluid_q == 4'd0) begin
          done_d   = 1'b1;
          status_d = ST_NO_FLUID;
        end else if (energy_i < burst_need) begin
          done_d   = 1'b1;
          status_d = ST_NO_ENERGY;
        end else begin
          fire_d        = 1'b1;
          fire_type_d   = choice_q;
          energy_draw_d = energy_cost;
          fluid_d       = fluid_q - 4'd1;
          shot_d        = shot_q + 2'd1;
          state_d       = S_BURST;
        end
      end

      S_RESP: begin
        if (resp_cool_q) begin
          cnt_d   = 8'd0;
          state_d = S_COOLDOWN;
        end else begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_COOLDOWN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == COOL_LAST) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_RELOAD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == RELOAD_DONE) begin
          done_d   = 1'b1;
          status_d = ST_OK;
          fluid_d  = FLUID_MAX_C;
        end
        if (cnt_q == RELOAD_LAST) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      status_q      <= ST_OK;
      choice_q      <= 8'd0;
      ready_q       <= 1'b1;
      fire_q        <= 1'b0;
      fire_type_q   <= 8'd0;
      energy_draw_q <= 8'd0;
      done_q        <= 1'b0;
      fluid_q       <= FLUID_MAX_C;
      tracer_q      <= TRACER_INIT_C;
      shot_q        <= 2'd0;
      cnt_q         <= 8'd0;
      resp_cool_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      choice_q      <= choice_d;
      ready_q       <= ready_d;
      fire_q        <= fire_d;
      fire_type_q   <= fire_type_d;
      energy_draw_q <= energy_draw_d;
      done_q        <= done_d;
      fluid_q       <= fluid_d;
      tracer_q      <= tracer_d;
      shot_q        <= shot_d;
      cnt_q         <= cnt_d;
      resp_cool_q   <= resp_cool_d;
    end
  end

  assign ready_o        = ready_q;
  assign fire_o         = fire_q;
  assign fire_type_o    = fire_type_q;
  assign energy_draw_o  = energy_draw_q;
  assign fluid_level_o  = fluid_q;
  assign tracer_count_o = tracer_q;
  assign done_o         = done_q;
  assign status_o       = status_q;

endmodule

// File: tb/tb_web_resource_checker.sv
// Self-checking bench for web_resource_checker: directed and random requests
// compared cycle by cycle against a request-level resource model.
module tb_web_resource_checker;

  localparam int COOLDOWN = 4;

  logic       clk;
  logic       reset;
  logic       req;
  logic [7:0] choice;
  logic [7:0] energy;
  logic [3:0] fluidtemp;
  logic       ready_o, fire_o, done_o;
  logic [7:0] fire_type_o, energy_draw_o;
  logic [3:0] fluid_level_o;
  logic [5:0] tracer_count_o;
  logic [2:0] status_o;

  int checks   = 0;
  int failures = 0;

  // Model of the resources the block owns.
  int m_fluid  = 15;
  int m_tracer = 40;

  // Costs indexed by choice bit: 0 reload, 1 tracer, 2 rapid, 3 taser,
  // 4 grenade, 5 splitter, 6 ricochet, 7 swing.
  int fl_cost [8] = '{0, 0, 1, 1, 4, 2, 1, 1};
  int en_cost [8] = '{0, 3, 2, 20, 10, 6, 4, 2};

  typedef struct {
    int         status;
    int         nshots;
    int         done_off;
    int         ready_off;
    logic [7:0] draw;
  } outcome_t;

  web_resource_checker dut (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req),
    .choice_i       (choice),
    .energy_i       (energy),
    .fluidtemp_i    (fluidtemp),
    .ready_o        (ready_o),
    .fire_o         (fire_o),
    .fire_type_o    (fire_type_o),
    .energy_draw_o  (energy_draw_o),
    .fluid_level_o  (fluid_level_o),
    .tracer_count_o (tracer_count_o),
    .done_o         (done_o),
    .status_o       (status_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outcome of one request in cycle offsets from the accepting edge, updating
  // the resource model as the request consumes fluid or tracers.
  function automatic outcome_t model_req(input logic [7:0] ch, input int e, input int t);
    outcome_t o;
    int idx;
    o.status = 0; o.nshots = 0; o.draw = 8'd0; idx = 0;
    if ($countones(ch) != 1) o.status = 5;
    else begin
      for (int b = 0; b < 8; b++) if (ch[b]) idx = b;
      if (idx != 0 && t > 12)               o.status = 4;
      else if (idx == 1 && m_tracer == 0)   o.status = 3;
      else if (m_fluid < fl_cost[idx])      o.status = 1;
      else if (e < en_cost[idx])            o.status = 2;
    end
    if (o.status != 0) begin
      o.done_off = 2; o.ready_off = 3;
      return o;
    end
    o.draw = 8'(en_cost[idx]);
    if (idx == 0) begin
      m_fluid = 15; o.done_off = 9; o.ready_off = 10;
    end else if (idx == 2) begin
      for (int k = 0; k < 3; k++) begin
        if (k > 0 && m_fluid < 1)       begin o.status = 1; break; end
        if (k > 0 && e < 2 * (k + 1))   begin o.status = 2; break; end
        m_fluid -= 1;
        o.nshots++;
      end
      o.done_off = o.nshots + 2;
      o.ready_off = o.done_off + 1 + COOLDOWN;
    end else begin
      o.nshots = 1;
      m_fluid -= fl_cost[idx];
      if (idx == 1) m_tracer -= 1;
      o.done_off = 2;
      o.ready_off = 3 + COOLDOWN;
    end
    return o;
  endfunction

  // Issue one request at a negedge with ready high and check every cycle
  // until ready returns. With hold set, req stays high through the request.
  task automatic run_req(input logic [7:0] ch, input logic [7:0] e, input logic [3:0] t,
                         input bit hold, input string tag);
    outcome_t o;
    bit exp_fire, exp_done;
    int guard;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready_before"}, ready_o, 1);
    o = model_req(ch, int'(e), int'(t));
    req = 1'b1; choice = ch; energy = e; fluidtemp = t;
    for (int off = 1; off <= o.ready_off; off++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      exp_fire = (off >= 2) && (off < 2 + o.nshots);
      exp_done = (off == o.done_off);
      check($sformatf("%s fire@%0d", tag, off), fire_o, exp_fire);
      check($sformatf("%s done@%0d", tag, off), done_o, exp_done);
      check($sformatf("%s ready@%0d", tag, off), ready_o, off == o.ready_off);
      check($sformatf("%s draw@%0d", tag, off), energy_draw_o, exp_fire ? o.draw : 8'd0);
      if (exp_fire) check($sformatf("%s type@%0d", tag, off), fire_type_o, ch);
      if (exp_done) check($sformatf("%s status@%0d", tag, off), status_o, o.status);
    end
    check({tag, " fluid"}, fluid_level_o, m_fluid);
    check({tag, " tracer"}, tracer_count_o, m_tracer);
  endtask

  initial begin
    logic [7:0] ch;
    int r, guard;
    reset = 1'b1; req = 1'b0; choice = 8'd0; energy = 8'd0; fluidtemp = 4'd0;
    repeat (3) @(negedge clk);
    check("rst ready", ready_o, 1);
    check("rst fire", fire_o, 0);
    check("rst type", fire_type_o, 0);
    check("rst draw", energy_draw_o, 0);
    check("rst done", done_o, 0);
    check("rst status", status_o, 0);
    check("rst fluid", fluid_level_o, 15);
    check("rst tracer", tracer_count_o, 40);
    reset = 1'b0;
    @(negedge clk);

    run_req(8'h80, 8'd50, 4'd5, 1'b0, "swing");
    run_req(8'h08, 8'd19, 4'd5, 1'b0, "taser_lowE");
    run_req(8'h10, 8'd50, 4'd13, 1'b0, "grenade_hot");
    run_req(8'h01, 8'd0, 4'd13, 1'b0, "reload_hot");
    run_req(8'h00, 8'd50, 4'd5, 1'b0, "zero_choice");
    run_req(8'h06, 8'd50, 4'd5, 1'b0, "two_hot");
    run_req(8'h02, 8'd50, 4'd5, 1'b0, "tracer");
    repeat (3) run_req(8'h10, 8'd50, 4'd5, 1'b0, "grenade");
    run_req(8'h80, 8'd50, 4'd5, 1'b0, "swing_to2");
    run_req(8'h04, 8'd100, 4'd5, 1'b0, "rapid_fluid2");
    run_req(8'h01, 8'd0, 4'd0, 1'b0, "reload");
    run_req(8'h80, 8'd50, 4'd5, 1'b1, "swing_held");
    run_req(8'h80, 8'd50, 4'd5, 1'b0, "swing_after_held");
    run_req(8'h04, 8'd4, 4'd5, 1'b0, "rapid_e4");
    run_req(8'h04, 8'd6, 4'd5, 1'b0, "rapid_e6");
    run_req(8'h08, 8'd20, 4'd12, 1'b0, "taser_edge");
    run_req(8'h20, 8'd5, 4'd0, 1'b0, "splitter_lowE");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) ch = 8'h01 << r;
      else       ch = 8'($urandom);
      run_req(ch, 8'($urandom_range(0, 40)), 4'($urandom_range(0, 15)), 1'b0, "rand");
    end

    guard = 0;
    while (m_tracer > 0 && guard < 60) begin
      run_req(8'h02, 8'd50, 4'd0, 1'b0, "drain");
      guard++;
    end
    run_req(8'h02, 8'd50, 4'd0, 1'b0, "tracer_empty");

    // Reset after the first burst shot abandons the request.
    run_req(8'h01, 8'd0, 4'd0, 1'b0, "reload_pre");
    req = 1'b1; choice = 8'h04; energy = 8'd100; fluidtemp = 4'd0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("burst first fire", fire_o, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_fluid = 15; m_tracer = 40;
    check("midrst ready", ready_o, 1);
    check("midrst fluid", fluid_level_o, 15);
    check("midrst tracer", tracer_count_o, 40);
    check("midrst done", done_o, 0);
    check("midrst fire", fire_o, 0);
    repeat (4) begin
      @(negedge clk);
      check("midrst no_done", done_o, 0);
    end
    run_req(8'h40, 8'd4, 4'd0, 1'b0, "ricochet_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/web_resource_checker.md
Name: web_resource_checker

Overview:
- Sits directly downstream of the web-type decoder stage and consumes its 8-bit one-hot web choice.
- On each request it checks the resources for that web type: suit energy, fluid cartridge level, tracer stock and fluid temperature.
- If the check passes it issues timed fire pulses with an energy-draw amount; otherwise it reports a status code.
- It owns the fluid cartridge and tracer counters and executes the reload sequence.

Parameters:
FLUID_MAX, 15, cartridge level after reset or reload (4-bit counter)
TRACER_INIT, 40, tracer count after reset (6-bit counter)
TEMP_LIMIT, 12, fluidtemp above this value means overheat
COOLDOWN, 4, idle cycles after a successful shot sequence before ready returns
RELOAD_CYCLES, 8, cycles spent in RELOAD

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req  in  1  request strobe; accepted only when ready=1
choice  in  8  one-hot web choice from decoder (bit7=swing ... bit0=reload)
energy  in  8  current suit energy level (unsigned)
fluidtemp  in  4  web-fluid temperature
ready  out  1  block can accept req
fire  out  1  one-cycle pulse per shot
fire_type  out  8  latched one-hot choice; valid while fire=1
energy_draw  out  8  energy consumed by this shot; valid with fire, else 0
fluid_level  out  4  cartridge level
tracer_count  out  6  remaining tracers
done  out  1  one-cycle pulse ending each request
status  out  3  result code; valid with done: 0 ok, 1 no fluid, 2 no energy, 3 no tracer, 4 overheat, 5 bad choice

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: ready=1, fire=0, fire_type=0, energy_draw=0, done=0, status=0, fluid_level=FLUID_MAX, tracer_count=TRACER_INIT, state=IDLE. Reset mid-operation abandons the request with no done pulse.
- Cost table (fluid/energy per shot):
  - swing (b7): 1/2
  - ricochet (b6): 1/4
  - splitter (b5): 2/6
  - grenade (b4): 4/10
  - taser (b3): 1/20
  - rapid (b2): 1/2 per shot, 3 shots
  - tracer (b1): 0 fluid, 1 tracer, 3 energy
  - reload (b0): no cost
- States: IDLE, CHECK, FIRE, BURST, COOLDOWN, RELOAD.
- IDLE: ready=1. On req, latch choice and go to CHECK. req while ready=0 is ignored.
- CHECK (cycle after accept): evaluate conditions in priority order; the first failing condition sets status:
  1. choice not one-hot (includes all-zero) -> 5
  2. fluidtemp > TEMP_LIMIT, non-reload only -> 4
  3. tracer web with tracer_count = 0 -> 3
  4. fluid_level < cost -> 1
  5. energy < cost -> 2
  - Failure: next cycle done=1 with status, then IDLE. No fire, no counter change, no cooldown.
  - Pass: next state is FIRE (single-shot types), BURST (rapid) or RELOAD (reload).
- FIRE (one cycle):
  - Outputs: fire=1, fire_type=latched choice, energy_draw=cost, done=1, status=0.
  - Counters: fluid_level or tracer_count decremented by cost in the same cycle.
  - Next state: COOLDOWN.
- Timing: request accepted at cycle N -> fire/done at cycle N+2 -> ready=1 again at cycle N+3+COOLDOWN.
- BURST:
  - Up to 3 fire pulses on consecutive cycles. First shot in the cycle after CHECK, already validated by CHECK.
  - Before each later shot k (k=1,2), recheck fluid_level>=1 and energy >= 2*(k+1). The energy input is not trusted to update mid-burst.
  - Recheck failure: stop; next cycle done=1 with status 1 or 2 (fluid checked first); then COOLDOWN, because at least one shot was fired.
  - After 3 shots: done=1, status=0 in the cycle after the third fire; then COOLDOWN.
- COOLDOWN: counts COOLDOWN cycles with ready=0, then IDLE.
- RELOAD:
  - Runs RELOAD_CYCLES cycles.
  - Final cycle: fluid_level=FLUID_MAX, done=1, status=0, then IDLE.
  - Reload on a full cartridge takes the same path. Overheat does not block reload. No fire pulse.
- Arithmetic: counters never wrap; the checks guarantee no underflow. Energy comparisons are unsigned 8-bit, with 2*(k+1) computed in 8 bits.
- Outputs: done and fire are registered pulses, never held more than one cycle per event. energy_draw is 0 whenever fire=0.

Test Plan:
- Reset, then req with choice=8'h80, energy=50, fluidtemp=5 -> at N+2: fire=1, fire_type=8'h80, energy_draw=2, done=1, status=0; fluid_level 15->14; ready=1 again at N+7.
- Taser (8'h08) with energy=19 -> done at N+2, status=2, fire never asserted, fluid_level unchanged, ready=1 at N+3.
- Rapid (8'h04) with fluid_level=2, energy=100 -> fire at N+2 and N+3, done at N+4 with status=1, fluid_level=0.
- Grenade (8'h10) with fluidtemp=13 -> status=4; then reload (8'h01) at the same temperature -> done after 8 RELOAD cycles, status=0, fluid_level=15.
- choice=8'h00 -> status=5; choice=8'h06 -> status=5. Tracer (8'h02) with tracer_count=0 -> status=3; with count 40 -> count 39, energy_draw=3.
- Assert reset during BURST after the first shot -> next cycle: ready=1, fluid_level=15, tracer_count=40, no done pulse. A req held high during COOLDOWN is ignored until ready=1.
